cop_spi_master: RTL and testbench

COP_SPI_MASTER -- requirements
Module: cop_spi_master

---
 rtl/cop_spi_master.sv | 233 +++++++++++++++++++++++
 tb/tb_cop_spi_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_spi_master.sv
// ============================================================================
// Module      : cop_spi_master
// Description : Single-byte SPI mode-0 master, LSB first, with an encoded
//               device select that can stay asserted across several bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DEV_SELECT_WIDTH
`define DEV_SELECT_WIDTH 3
`endif
`ifndef DEV_SELECT_NONE
`define DEV_SELECT_NONE 3'b111
`endif

module cop_spi_master #(
  parameter int                 CLK_DIV  = 2,
  parameter int                 SEL_W    = `DEV_SELECT_WIDTH,
  parameter logic [SEL_W-1:0]   SEL_NONE = `DEV_SELECT_NONE
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [SEL_W-1:0]  dev_sel,
  input  logic [7:0]        tx_byte,
  input  logic              last,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rx_byte,
  output logic [SEL_W-1:0]  cop_nss,
  output logic              cop_sck,
  output logic              cop_mosi,
  input  logic              cop_miso
);

  localparam int             CW        = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DESEL  = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_LOW    = 3'd3;
  localparam logic [2:0] S_HIGH   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_GUARD  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    hcnt_q, hcnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             last_q, last_d;
  logic             none_q, none_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [SEL_W-1:0] nss_q, nss_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;

  logic             hdone;
  logic             accept;

  assign hdone  = (hcnt_q == HALF_LAST);
  assign accept = (state_q == S_IDLE) && start;

  // State and counter register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state logic: half-period timing and bit sequencing
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hcnt_d = '0;
          bcnt_d = '0;
          if (dev_sel == SEL_NONE)
            state_d = S_GUARD;
          else if ((nss_q == SEL_NONE) || (nss_q == dev_sel))
            state_d = S_SELECT;
          else
            state_d = S_DESEL;
        end
      end
      S_DESEL: begin
        if (hdone) begin
          hcnt_d  = '0;
          state_d = S_SELECT;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_SELECT: begin
        hcnt_d  = '0;
        state_d = S_LOW;
      end
      S_LOW: begin
        if (hdone) begin
          hcnt_d  = '0;
          state_d = S_HIGH;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (hdone) begin
          hcnt_d = '0;
          if (bcnt_q == 3'd7) begin
            bcnt_d  = '0;
            state_d = S_FINISH;
          end else begin
            bcnt_d  = bcnt_q + 3'd1;
            state_d = S_LOW;
          end
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        hcnt_d  = '0;
        state_d = last_q ? S_GUARD : S_IDLE;
      end
      S_GUARD: begin
        if (hdone) begin
          hcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        hcnt_d  = '0;
        bcnt_d  = '0;
      end
    endcase
  end

  // Request capture and shift registers; miso is taken as sck leaves HIGH
  always_comb begin
    sel_d   = sel_q;
    tx_d    = tx_q;
    last_d  = last_q;
    none_d  = none_q;
    rx_sh_d = rx_sh_q;
    if (accept) begin
      sel_d  = dev_sel;
      tx_d   = tx_byte;
      last_d = last;
      none_d = (dev_sel == SEL_NONE);
    end else if ((state_q == S_HIGH) && hdone) begin
      tx_d    = {1'b0, tx_q[7:1]};
      rx_sh_d = {cop_miso, rx_sh_q[7:1]};
    end
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH) ||
                ((state_q == S_GUARD) && hdone && none_q);
    sck_d     = (state_d == S_HIGH);
    mosi_d    = 1'b0;
    rx_byte_d = rx_byte_q;
    nss_d     = nss_q;
    case (state_d)
      S_DESEL, S_GUARD: nss_d = SEL_NONE;
      S_SELECT, S_LOW, S_HIGH: begin
        nss_d  = sel_d;
        mosi_d = tx_d[0];
      end
      S_FINISH: begin
        nss_d     = sel_q;
        rx_byte_d = rx_sh_d;
      end
      default: nss_d = nss_q;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sel_q     <= '0;
      tx_q      <= '0;
      last_q    <= 1'b0;
      none_q    <= 1'b0;
      rx_sh_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_byte_q <= 8'h00;
      nss_q     <= SEL_NONE;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      tx_q      <= tx_d;
      last_q    <= last_d;
      none_q    <= none_d;
      rx_sh_q   <= rx_sh_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_byte_q <= rx_byte_d;
      nss_q     <= nss_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_byte  = rx_byte_q;
  assign cop_nss  = nss_q;
  assign cop_sck  = sck_q;
  assign cop_mosi = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_cop_spi_master.sv
// ============================================================================
// Module      : tb_cop_spi_master
// Description : Directed self-checking bench for cop_spi_master (CLK_DIV=2
//               instance for byte/frame tests, CLK_DIV=1 instance for
//               continuous-start throughput).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cop_spi_master;

  localparam logic [2:0] NONE   = 3'b111;
  localparam logic [2:0] LOGIC  = 3'd0;
  localparam logic [2:0] FLASH  = 3'd1;
  localparam logic [2:0] USB    = 3'd2;
  localparam logic [2:0] SDCARD = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset = 1'b0;

  logic       a_start = 1'b0, a_last = 1'b0;
  logic [2:0] a_sel = 3'd0;
  logic [7:0] a_tx = 8'h00;
  logic       a_busy, a_done, a_sck, a_mosi;
  logic       a_miso = 1'b0;
  logic [7:0] a_rx;
  logic [2:0] a_nss;

  logic       b_start = 1'b0, b_last = 1'b0;
  logic [2:0] b_sel = 3'd0;
  logic [7:0] b_tx = 8'h00;
  logic       b_busy, b_done, b_sck, b_mosi;
  logic       b_miso = 1'b0;
  logic [7:0] b_rx;
  logic [2:0] b_nss;

  cop_spi_master #(.CLK_DIV(2), .SEL_W(3), .SEL_NONE(NONE)) u_dut_a (
    .clk(clk), .nreset(nreset), .start(a_start), .dev_sel(a_sel),
    .tx_byte(a_tx), .last(a_last), .busy(a_busy), .done(a_done),
    .rx_byte(a_rx), .cop_nss(a_nss), .cop_sck(a_sck), .cop_mosi(a_mosi),
    .cop_miso(a_miso)
  );

  cop_spi_master #(.CLK_DIV(1), .SEL_W(3), .SEL_NONE(NONE)) u_dut_b (
    .clk(clk), .nreset(nreset), .start(b_start), .dev_sel(b_sel),
    .tx_byte(b_tx), .last(b_last), .busy(b_busy), .done(b_done),
    .rx_byte(b_rx), .cop_nss(b_nss), .cop_sck(b_sck), .cop_mosi(b_mosi),
    .cop_miso(b_miso)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitors / slave model (negedge sampling) ----------
  int         cyc = 0;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] a_bit = 3'd0;
  logic [7:0] a_mosi_log = 8'h00;
  logic       a_sck_p = 1'b0, a_done_p = 1'b0;
  logic [2:0] a_nss_p = NONE;
  int a_rises = 0, a_hi_run = 0, a_hi_bad = 0, a_per_bad = 0;
  int a_last_rise = -100, a_none_busy = 0, a_dones = 0, viol_a = 0;

  logic       b_sck_p = 1'b0, b_done_p = 1'b0;
  logic [2:0] b_nss_p = NONE;
  int b_rises = 0, b_hi_run = 0, b_hi_bad = 0, b_per_bad = 0;
  int b_last_rise = -100, b_dones = 0, viol_b = 0;
  int b_done_at [0:7];

  always @(negedge clk) begin
    cyc++;
    if (nreset) begin
      if (a_nss == NONE) a_bit = 3'd0;
      if (a_sck && !a_sck_p) begin
        a_mosi_log = {a_mosi, a_mosi_log[7:1]};
        a_miso     = slave_byte[a_bit];
        a_bit      = a_bit + 3'd1;
        a_rises++;
        if ((cyc - a_last_rise) < 7 && (cyc - a_last_rise) != 4) a_per_bad++;
        a_last_rise = cyc;
      end
      if (a_sck) a_hi_run++;
      else if (a_sck_p) begin
        if (a_hi_run != 2) a_hi_bad++;
        a_hi_run = 0;
      end
      if (a_nss == NONE && a_busy) a_none_busy++;
      if (a_done) a_dones++;
      if (a_sck && a_nss == NONE) viol_a++;
      if (a_nss != a_nss_p && (a_sck || a_sck_p)) viol_a++;
      if ((!a_busy || a_nss == NONE) && a_mosi) viol_a++;
      if (a_done && a_done_p) viol_a++;

      if (b_sck && !b_sck_p) begin
        b_rises++;
        if ((cyc - b_last_rise) < 4 && (cyc - b_last_rise) != 2) b_per_bad++;
        b_last_rise = cyc;
      end
      if (b_sck) b_hi_run++;
      else if (b_sck_p) begin
        if (b_hi_run != 1) b_hi_bad++;
        b_hi_run = 0;
      end
      if (b_done) begin
        if (b_dones < 8) b_done_at[b_dones] = cyc;
        b_dones++;
      end
      if (b_sck && b_nss == NONE) viol_b++;
      if (b_nss != b_nss_p && (b_sck || b_sck_p)) viol_b++;
      if ((!b_busy || b_nss == NONE) && b_mosi) viol_b++;
      if (b_done && b_done_p) viol_b++;
    end else begin
      a_bit    = 3'd0;
      a_hi_run = 0;
      b_hi_run = 0;
    end
    a_sck_p = a_sck; a_nss_p = a_nss; a_done_p = a_done;
    b_sck_p = b_sck; b_nss_p = b_nss; b_done_p = b_done;
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] sel, input logic [7:0] tx, input logic lst);
    a_sel   = sel;
    a_tx    = tx;
    a_last  = lst;
    a_start = 1'b1;
  endtask

  // edges from the start cycle until done is seen; -1 if never
  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      a_start = 1'b0;
      @(negedge clk);
      if (a_done) begin
        n = k;
        break;
      end
    end
  endtask

  // edges from the done cycle until busy is low; -1 if never
  task automatic wait_idle(output int n);
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (!a_busy) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, nb0, d0, c0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_rx",   a_rx,   8'h00);
    check("rst_nss",  a_nss,  NONE);
    check("rst_sck",  a_sck,  1'b0);
    check("rst_mosi", a_mosi, 1'b0);
    nreset = 1'b1;
    repeat (2) tick();

    // single byte to LOGIC with release
    slave_byte = 8'h3C;
    r0 = a_rises;
    go(LOGIC, 8'hA5, 1'b1);
    wait_done(n);
    check("t1_latency", n, 34);
    check("t1_rx", a_rx, 8'h3C);
    wait_idle(n);
    check("t1_busy_fall", n, 3);
    check("t1_nss_released", a_nss, NONE);
    check("t1_rises", a_rises - r0, 8);
    check("t1_mosi_seq", a_mosi_log, 8'hA5);

    // two bytes to FLASH in one frame
    slave_byte = 8'h96;
    r0  = a_rises;
    nb0 = a_none_busy;
    go(FLASH, 8'h03, 1'b0);
    wait_done(n);
    check("t2_latency1", n, 34);
    check("t2_rx1", a_rx, 8'h96);
    wait_idle(n);
    check("t2_busy_fall1", n, 1);
    check("t2_nss_held", a_nss, FLASH);
    go(FLASH, 8'h00, 1'b1);
    wait_done(n);
    check("t2_latency2", n, 34);
    check("t2_mosi2", a_mosi_log, 8'h00);
    wait_idle(n);
    check("t2_busy_fall2", n, 3);
    check("t2_rises", a_rises - r0, 16);
    check("t2_nss_none_cycles", a_none_busy - nb0, 2);

    // USB frame left open, then SDCARD forces a deselect gap
    slave_byte = 8'h5A;
    go(USB, 8'h11, 1'b0);
    wait_done(n);
    check("t3_latency_usb", n, 34);
    wait_idle(n);
    check("t3_usb_held", a_nss, USB);
    nb0 = a_none_busy;
    go(SDCARD, 8'h22, 1'b1);
    wait_done(n);
    check("t3_latency_sd", n, 36);
    check("t3_rx", a_rx, 8'h5A);
    check("t3_mosi", a_mosi_log, 8'h22);
    wait_idle(n);
    check("t3_nss_none_cycles", a_none_busy - nb0, 4);

    // start with the idle select code: guard only, no clocks
    r0 = a_rises;
    go(NONE, 8'hFF, 1'b1);
    wait_done(n);
    check("t4_latency", n, 3);
    check("t4_busy_at_done", a_busy, 1'b0);
    check("t4_rx_kept", a_rx, 8'h5A);
    check("t4_rises", a_rises - r0, 0);
    tick();

    // starts while busy are ignored
    slave_byte = 8'hC3;
    r0 = a_rises;
    d0 = a_dones;
    go(LOGIC, 8'h0F, 1'b1);
    tick();
    a_start = 1'b0;
    repeat (5) tick();
    a_sel = FLASH; a_tx = 8'hF0; a_last = 1'b0; a_start = 1'b1;
    repeat (3) tick();
    a_start = 1'b0;
    wait_done(n);
    check("t5_latency", n + 9, 34);
    check("t5_rx", a_rx, 8'hC3);
    check("t5_mosi", a_mosi_log, 8'h0F);
    wait_idle(n);
    repeat (4) tick();
    check("t5_stays_idle", a_busy, 1'b0);
    check("t5_one_transfer", a_dones - d0, 1);

    // reset in the middle of a byte
    slave_byte = 8'h81;
    r0 = a_rises;
    d0 = a_dones;
    go(LOGIC, 8'h00, 1'b1);
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_rises - r0 >= 4) break;
    end
    check("t6_reached_4th_rise", (a_rises - r0) >= 4, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check("t6_rst_busy", a_busy, 1'b0);
    check("t6_rst_sck",  a_sck,  1'b0);
    check("t6_rst_nss",  a_nss,  NONE);
    check("t6_rst_rx",   a_rx,   8'h00);
    check("t6_rst_mosi", a_mosi, 1'b0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    tick();
    check("t6_no_done", a_dones - d0, 0);
    go(LOGIC, 8'hFF, 1'b1);
    wait_done(n);
    check("t6_latency_after", n, 34);
    check("t6_rx_after", a_rx, 8'h81);
    check("t6_mosi_after", a_mosi_log, 8'hFF);
    wait_idle(n);
    check("t6_busy_fall", n, 3);

    // CLK_DIV=1 instance with start held high
    b_sel = LOGIC; b_tx = 8'h00; b_last = 1'b1; b_start = 1'b1;
    c0 = cyc;
    repeat (65) tick();
    b_start = 1'b0;
    repeat (25) tick();
    check("b_transfers", b_dones, 4);
    check("b_first_latency", b_done_at[0] - c0 - 1, 18);
    check("b_period1", b_done_at[1] - b_done_at[0], 20);
    check("b_period2", b_done_at[2] - b_done_at[1], 20);
    check("b_rises", b_rises, 32);
    check("b_sck_high_len_bad", b_hi_bad, 0);
    check("b_sck_period_bad", b_per_bad, 0);
    check("b_rx", b_rx, 8'h00);

    check("a_sck_high_len_bad", a_hi_bad, 0);
    check("a_sck_period_bad", a_per_bad, 0);
    check("a_invariants", viol_a, 0);
    check("b_invariants", viol_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
